// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared definitions for the one-hot request/grant arbiter and its requesters
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_XFER    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_BACKOFF = 3'd4
    } arb_state_e;

    localparam logic [NUM_REQ-1:0] GNT_NONE = 4'b0000;
    localparam logic [NUM_REQ-1:0] GNT_REQ0 = 4'b0001;
    localparam logic [NUM_REQ-1:0] GNT_REQ1 = 4'b0010;
    localparam logic [NUM_REQ-1:0] GNT_REQ2 = 4'b0100;
    localparam logic [NUM_REQ-1:0] GNT_REQ3 = 4'b1000;

    function automatic logic [NUM_REQ-1:0] gnt_onehot(input logic [1:0] id);
        logic [NUM_REQ-1:0] v;
        v     = GNT_NONE;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - count-based synchronous FIFO with first-word-fall-through head
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    // Full is judged on registered occupancy, so a pop never frees space in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - requester agent: buffers words, requests the bus, streams bounded bursts
module arb_requester
    import arb_pkg::*;
#(
    parameter int ID           = 0,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 8,
    parameter int MAX_BURST    = 4,
    parameter int TIMEOUT      = 8,
    parameter int BACKOFF_BASE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              busy,
    output logic [7:0]        retry_cnt
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int BW     = $clog2(MAX_BURST + 1);
    localparam int BO_LEN = BACKOFF_BASE + ID;
    // The IDLE cycle after BACKOFF is also a req-low cycle, so BACKOFF itself is one shorter.
    localparam int BO_CYC = (BO_LEN > 1) ? BO_LEN - 1 : 1;

    arb_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic [15:0]       wait_q, wait_d;
    logic [15:0]       bo_q, bo_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [7:0]        retry_q, retry_d;

    logic              fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              push_acc;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr_ready  = !fifo_full;
    assign push_acc  = wr_valid && wr_ready;
    assign req       = req_q;
    assign busy      = (state_q != ST_IDLE);
    assign retry_cnt = retry_q;
    assign bus_data  = bus_valid ? fifo_head : '0;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bo_d      = bo_q;
        beat_d    = beat_q;
        retry_d   = retry_q;
        fifo_pop  = 1'b0;
        bus_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                bo_d   = '0;
                if (!fifo_empty && !gnt) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (gnt) begin
                    state_d = ST_XFER;
                    beat_d  = '0;
                end else if (wait_q == 16'(TIMEOUT - 1)) begin
                    state_d = ST_BACKOFF;
                    bo_d    = '0;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_XFER: begin
                if (!gnt) begin
                    state_d = ST_RELEASE;
                end else if (!fifo_empty) begin
                    bus_valid = 1'b1;
                    fifo_pop  = 1'b1;
                    beat_d    = beat_q + BW'(1);
                    // Burst ends at the beat limit or when this pop drains the FIFO.
                    if (beat_q == BW'(MAX_BURST - 1) ||
                        (fifo_count == CW'(1) && !push_acc)) begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!gnt) state_d = ST_IDLE;
            end
            ST_BACKOFF: begin
                if (bo_q == 16'(BO_CYC - 1)) state_d = ST_IDLE;
                else                         bo_d    = bo_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_REQ) || (state_d == ST_XFER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wait_q  <= '0;
            bo_q    <= '0;
            beat_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            bo_q    <= bo_d;
            beat_q  <= beat_d;
            retry_q <= retry_d;
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - scoreboard bench for arb_requester wired to an arbiter model
module tb_arb_requester;

    localparam int ID           = 2;
    localparam int DATA_W       = 8;
    localparam int DEPTH        = 8;
    localparam int MAX_BURST    = 4;
    localparam int TIMEOUT      = 8;
    localparam int BACKOFF_BASE = 4;
    localparam int BO_LOW       = BACKOFF_BASE + ID;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              req;
    logic              gnt;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              busy;
    logic [7:0]        retry_cnt;

    logic              req0;
    logic              gnt_kill;
    logic [3:0]        gnt_vec;
    logic [3:0]        arb_req;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          burst_log[$];
    int          run_len = 0;
    int          beats_total = 0;
    bit          seen_99 = 0;
    int          beats_at_gnt0 = -1;

    always #5 clk = ~clk;

    arb_requester #(
        .ID           (ID),
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .MAX_BURST    (MAX_BURST),
        .TIMEOUT      (TIMEOUT),
        .BACKOFF_BASE (BACKOFF_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .req       (req),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .busy      (busy),
        .retry_cnt (retry_cnt)
    );

    // Arbiter model: holder keeps the grant while requesting, otherwise only a lone request wins.
    assign arb_req = {1'b0, req, 1'b0, req0};
    always @(posedge clk or posedge rst) begin
        if (rst)                                        gnt_vec <= 4'b0;
        else if ((gnt_vec & arb_req) != 4'b0)           gnt_vec <= gnt_vec;
        else if (arb_req != 4'b0 && (arb_req & (arb_req - 4'd1)) == 4'b0) gnt_vec <= arb_req;
        else                                            gnt_vec <= 4'b0;
    end
    assign gnt = gnt_vec[ID] & ~gnt_kill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else if (bus_valid) begin
            chk("bus_valid_without_gnt", {31'd0, gnt}, 32'd1);
            if (bus_data == 8'h99) seen_99 = 1;
            if (exp_q.size() == 0) chk("bus_word_unexpected", 32'd1, 32'd0);
            else                   chk("bus_data", {24'd0, bus_data}, {24'd0, exp_q.pop_front()});
            run_len++;
            beats_total++;
        end else begin
            chk("bus_data_zero_when_idle", {24'd0, bus_data}, 32'd0);
            if (run_len > 0) begin
                chk("burst_len_le_max", {31'd0, run_len <= MAX_BURST}, 32'd1);
                burst_log.push_back(run_len);
                run_len = 0;
            end
        end
    end

    task automatic push_word(input logic [7:0] d, output bit acc);
        wr_valid = 1'b1;
        wr_data  = d;
        acc      = wr_ready;
        if (acc) exp_q.push_back(d);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_bus(input bit lvl, input string name);
        int n = 0;
        while (bus_valid !== lvl && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {31'd0, n < 50}, 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {31'd0, n < budget}, 32'd1);
    endtask

    task automatic model_req0();
        int n = 0;
        req0 = 1'b1;
        repeat (TIMEOUT) begin @(posedge clk); #1; end
        req0 = 1'b0;
        repeat (BACKOFF_BASE) begin @(posedge clk); #1; end
        req0 = 1'b1;
        while (!gnt_vec[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("id0_granted", {31'd0, n < 40}, 32'd1);
        beats_at_gnt0 = beats_total;
        repeat (3) begin @(posedge clk); #1; end
        req0 = 1'b0;
    endtask

    initial begin
        bit acc;
        int n;
        int b0;
        int bk;
        bit any_act;

        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; req0 = 1'b0; gnt_kill = 1'b0;
        #1;
        chk("rst_wr_ready",  {31'd0, wr_ready},  32'd1);
        chk("rst_req",       {31'd0, req},       32'd0);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_bus_data",  {24'd0, bus_data},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_retry_cnt", {24'd0, retry_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Two-word burst and release timing
        burst_log.delete();
        push_word(8'h11, acc);
        push_word(8'h22, acc);
        chk("t1_req_next_edge", {31'd0, req}, 32'd1);
        wait_bus(1'b1, "t1_bus_start");
        wait_bus(1'b0, "t1_bus_end");
        chk("t1_req_low_after_last", {31'd0, req}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_idle_two_later", {31'd0, busy}, 32'd0);
        chk("t1_burst_count", burst_log.size(), 32'd1);
        if (burst_log.size() > 0) chk("t1_burst_len", burst_log[0], 32'd2);

        // Six words split into bursts of 4 and 2
        burst_log.delete();
        for (int i = 0; i < 6; i++) push_word(8'($urandom_range(0, 255)), acc);
        wait_drain("t2_drain", 100);
        chk("t2_burst_count", burst_log.size(), 32'd2);
        if (burst_log.size() == 2) begin
            chk("t2_burst0_len", burst_log[0], MAX_BURST);
            chk("t2_burst1_len", burst_log[1], 32'd2);
        end

        // Collision with requester 0: timeout, staggered backoff, ID 0 wins first
        chk("t3_retry_before", {24'd0, retry_cnt}, 32'd0);
        b0 = beats_total;
        push_word(8'h5A, acc);
        @(posedge clk); #1;
        chk("t3_req_rise", {31'd0, req}, 32'd1);
        fork
            model_req0();
            begin
                n = 1;
                while (req && n < 40) begin @(posedge clk); #1; if (req) n++; end
                chk("t3_req_high_len", n, TIMEOUT);
                chk("t3_retry_cnt", {24'd0, retry_cnt}, 32'd1);
                n = 0;
                while (!req && n < 40) begin n++; @(posedge clk); #1; end
                chk("t3_req_low_len", n, BO_LOW);
            end
        join
        wait_drain("t3_drain", 100);
        chk("t3_id0_first", beats_at_gnt0, b0);
        chk("t3_id2_sent", beats_total, b0 + 1);

        // Fill with grant blocked; overflow word rejected and never on the bus
        gnt_kill = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_word(8'($urandom_range(0, 127)), acc);
            chk("t4_fill_accept", {31'd0, acc}, 32'd1);
        end
        chk("t4_wr_ready_full", {31'd0, wr_ready}, 32'd0);
        push_word(8'h99, acc);
        chk("t4_overflow_rejected", {31'd0, acc}, 32'd0);
        gnt_kill = 1'b0;
        wait_drain("t4_drain", 300);
        chk("t4_no_99_on_bus", {31'd0, seen_99}, 32'd0);

        // Reset after two beats of a burst
        b0 = beats_total;
        for (int i = 0; i < 6; i++) push_word(8'($urandom_range(0, 255)), acc);
        n = 0;
        while (beats_total < b0 + 2 && n < 60) begin @(posedge clk); #1; n++; end
        chk("t5_two_beats", {31'd0, n < 60}, 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t5_req_reset",       {31'd0, req},       32'd0);
        chk("t5_bus_valid_reset", {31'd0, bus_valid}, 32'd0);
        chk("t5_busy_reset",      {31'd0, busy},      32'd0);
        chk("t5_wr_ready_reset",  {31'd0, wr_ready},  32'd1);
        chk("t5_retry_reset",     {24'd0, retry_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        any_act = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (req || bus_valid || busy) any_act = 1;
        end
        chk("t5_fifo_empty_after_reset", {31'd0, any_act}, 32'd0);

        // Grant lost mid-burst
        b0 = beats_total;
        for (int i = 0; i < 4; i++) push_word(8'($urandom_range(0, 255)), acc);
        n = 0;
        while (beats_total < b0 + 1 && n < 60) begin @(posedge clk); #1; n++; end
        chk("t6_first_beat", {31'd0, n < 60}, 32'd1);
        gnt_kill = 1'b1;
        bk = beats_total;
        @(posedge clk); #1;
        chk("t6_req_drop", {31'd0, req}, 32'd0);
        @(posedge clk); #1;
        chk("t6_idle_after_release", {31'd0, busy}, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        chk("t6_no_beats_while_lost", beats_total, bk);
        gnt_kill = 1'b0;
        wait_drain("t6_drain", 200);

        // Randomised traffic
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                push_word(8'($urandom_range(0, 255)), acc);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            wait_drain("rand_drain", 300);
        end
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
